// File: rtl/apple1_clk_pkg.sv
// Shared definitions for the Apple 1 clock-enable and reset sequencer:
// sequencer state encoding, button constants and the divisor-list accessor.
package apple1_clk_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int   SYNC_DEPTH     = 2;
    localparam logic BTN_RELEASED   = 1'b1;
    localparam int   DIV_LIST_MAX_W = 128;

    // Extract divisor idx from a packed list of w-bit fields (field 0 at the LSBs).
    function automatic int unsigned div_of(
        input logic [DIV_LIST_MAX_W-1:0] list,
        input int                        idx,
        input int                        w
    );
        logic [DIV_LIST_MAX_W-1:0] mask;
        logic [31:0]               val;
        mask = (DIV_LIST_MAX_W'(1'b1) << w) - DIV_LIST_MAX_W'(1'b1);
        val  = 32'((list >> (idx * w)) & mask);
        return val;
    endfunction

endpackage

// File: rtl/apple1_debounce.sv
// Reset push-button conditioning: 2-FF synchronizer followed by a debounce
// counter that accepts a new level only after DEB_CYCLES stable cycles.
module apple1_debounce
    import apple1_clk_pkg::*;
#(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk25,
    input  logic rst,
    input  logic btn_n,
    output logic btn_db
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  db_r;
    logic                  level_s;

    // metastability synchronizer, resets to the released level
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_DEPTH{BTN_RELEASED}};
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], btn_n};
        end
    end

    assign level_s = sync_r[SYNC_DEPTH-1];

    // any return to the accepted level restarts the stability count
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            db_r  <= BTN_RELEASED;
        end else if (level_s == db_r) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            db_r  <= level_s;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign btn_db = db_r;

endmodule

// File: rtl/apple1_clk_rst_gen.sv
// Apple 1 board clock-enable divider bank and stretched core-reset sequencer.
// Optional channel-0 single-step gating is built when CLKGEN_STEP_EN is defined.
module apple1_clk_rst_gen
    import apple1_clk_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      DIV_W       = 8,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_LIST    = {8'd25, 8'd1},
    parameter int                      HOLD_CYCLES = 1024,
    parameter int                      DEB_CYCLES  = 250000
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              btn_n,
`ifdef CLKGEN_STEP_EN
    input  logic              step_mode,
    input  logic              step_req,
`endif
    output logic [NUM_CH-1:0] ce,
    output logic              sys_rst_n,
    output logic              running
);

    localparam int                        HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]         HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_LIST_MAX_W-1:0] DIV_EXT   = DIV_LIST_MAX_W'(DIV_LIST);

    logic              btn_db_s;
    logic              pressed_s;
    seq_state_t        state_r;
    seq_state_t        state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
    logic              run_s;
    logic              running_r;
    logic              sys_rst_n_r;
    logic              run_en_s;
    logic [NUM_CH-1:0] tick_s;
    logic [NUM_CH-1:0] gated_s;
    logic [NUM_CH-1:0] ce_r;

    apple1_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk25 (clk25),
        .rst   (rst),
        .btn_n (btn_n),
        .btn_db(btn_db_s)
    );

    assign pressed_s = (btn_db_s != BTN_RELEASED);

    // sequencer state register
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_r    <= HOLD;
            hold_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    // next state: a press always restarts the full stretch
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            HOLD: begin
                if (pressed_s) begin
                    hold_cnt_nxt_s = '0;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s    = RUN;
                    hold_cnt_nxt_s = '0;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 1'b1;
                end
            end
            RUN: begin
                if (pressed_s) begin
                    state_nxt_s    = HOLD;
                    hold_cnt_nxt_s = '0;
                end else begin
                    hold_cnt_nxt_s = '0;
                end
            end
            default: begin
                state_nxt_s    = HOLD;
                hold_cnt_nxt_s = '0;
            end
        endcase
    end

    // sequencer output decode
    always_comb begin
        run_s = (state_r == RUN);
    end

    // registered reset and status outputs
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            running_r   <= 1'b0;
            sys_rst_n_r <= 1'b0;
        end else begin
            running_r   <= run_s;
            sys_rst_n_r <= run_s;
        end
    end

    // dividers start together once the core sees reset released
    assign run_en_s = run_s & running_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(div_of(DIV_EXT, i, DIV_W) - 32'd1);
        logic [DIV_W-1:0] cnt_r;

        // channel divider, held at zero outside RUN
        always_ff @(posedge clk25 or posedge rst) begin
            if (rst) begin
                cnt_r <= '0;
            end else if (!run_en_s) begin
                cnt_r <= '0;
            end else if (cnt_r == DIV_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end

        assign tick_s[i] = run_en_s && (cnt_r == DIV_LAST);
    end

`ifdef CLKGEN_STEP_EN
    logic step_req_d_r;
    logic armed_r;

    // single-step arming: one natural channel-0 tick per step_req rising edge
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            step_req_d_r <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            step_req_d_r <= step_req;
            if (!run_s) begin
                armed_r <= 1'b0;
            end else if (armed_r && tick_s[0]) begin
                armed_r <= 1'b0;
            end else if (!armed_r && step_req && !step_req_d_r) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // channel 0 passes only when free-running or armed
    always_comb begin
        gated_s    = tick_s;
        gated_s[0] = tick_s[0] & (~step_mode | armed_r);
    end
`else
    assign gated_s = tick_s;
`endif

    // clock-enable output register
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            ce_r <= '0;
        end else begin
            ce_r <= gated_s;
        end
    end

    assign ce        = ce_r;
    assign sys_rst_n = sys_rst_n_r;
    assign running   = running_r;

endmodule

// File: tb/tb_apple1_clk_rst_gen.sv
// Self-checking bench for apple1_clk_rst_gen: directed scenarios plus random
// button activity, compared against a cycle-level behavioural reference model.
module tb_apple1_clk_rst_gen;

    localparam int NCH      = 3;
    localparam int HOLD     = 16;
    localparam int DEB      = 8;
    localparam int HIST_LEN = DEB + 2;
`ifdef CLKGEN_STEP_EN
    localparam logic [23:0] DIVS_PACKED = {8'd255, 8'd1, 8'd4};
    localparam int DIV_A [NCH] = '{4, 1, 255};
    localparam int ONE_CH  = 1;
    localparam int QUAD_CH = 0;
`else
    localparam logic [23:0] DIVS_PACKED = {8'd255, 8'd4, 8'd1};
    localparam int DIV_A [NCH] = '{1, 4, 255};
    localparam int ONE_CH  = 0;
    localparam int QUAD_CH = 1;
`endif

    logic           clk25 = 1'b0;
    logic           rst;
    logic           btn_n;
    logic [NCH-1:0] ce;
    logic           sys_rst_n;
    logic           running;
`ifdef CLKGEN_STEP_EN
    logic           step_mode;
    logic           step_req;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    int             m_edge;
    int             m_streak;
    int             m_run_edge;
    bit             m_db;
    bit             m_run;
    bit             m_running;
    bit [NCH-1:0]   m_ce;
    bit             hist[$];
`ifdef CLKGEN_STEP_EN
    bit             m_armed;
    bit             m_step_prev;
`endif

    apple1_clk_rst_gen #(
        .NUM_CH     (NCH),
        .DIV_W      (8),
        .DIV_LIST   (DIVS_PACKED),
        .HOLD_CYCLES(HOLD),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk25    (clk25),
        .rst      (rst),
        .btn_n    (btn_n),
`ifdef CLKGEN_STEP_EN
        .step_mode(step_mode),
        .step_req (step_req),
`endif
        .ce       (ce),
        .sys_rst_n(sys_rst_n),
        .running  (running)
    );

    always #5 clk25 = ~clk25;

    task automatic model_reset();
        m_edge     = 0;
        m_streak   = 0;
        m_run_edge = 0;
        m_db       = 1'b1;
        m_run      = 1'b0;
        m_running  = 1'b0;
        m_ce       = '0;
        hist.delete();
        for (int k = 0; k < HIST_LEN; k++) hist.push_back(1'b1);
`ifdef CLKGEN_STEP_EN
        m_armed     = 1'b0;
        m_step_prev = 1'b0;
`endif
    endtask

    // One clock edge of the specification's rules, using pre-edge values.
    task automatic model_step();
        bit           db_pre;
        bit           run_pre;
        bit           all_diff;
        bit [NCH-1:0] nat;
        int           e;
        db_pre  = m_db;
        run_pre = m_run;
        m_edge  = m_edge + 1;
        e       = m_edge;
        if (run_pre && !m_running) m_run_edge = e;
        m_running = run_pre;
        for (int i = 0; i < NCH; i++)
            nat[i] = run_pre && (e > m_run_edge) && (((e - m_run_edge) % DIV_A[i]) == 0);
        m_ce = nat;
`ifdef CLKGEN_STEP_EN
        if (step_mode && !m_armed) m_ce[0] = 1'b0;
        if (!run_pre) m_armed = 1'b0;
        else if (m_armed && nat[0]) m_armed = 1'b0;
        else if (!m_armed && step_req && !m_step_prev) m_armed = 1'b1;
        m_step_prev = step_req;
`endif
        // button level must have differed from the accepted one for DEB cycles
        hist.push_back(btn_n);
        if (hist.size() > HIST_LEN) void'(hist.pop_front());
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (hist[k] == db_pre) all_diff = 1'b0;
        if (all_diff) m_db = !db_pre;
        if (!run_pre) begin
            if (db_pre) begin
                m_streak = m_streak + 1;
                if (m_streak == HOLD) begin
                    m_run    = 1'b1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else if (!db_pre) begin
            m_run    = 1'b0;
            m_streak = 0;
        end
    endtask

    initial begin : ref_model
        model_reset();
        forever begin
            @(posedge clk25 or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    task automatic test_reset();
        rst   = 1'b1;
        btn_n = 1'b1;
        repeat (3) @(negedge clk25);
        n_cmp++; if (ce !== {NCH{1'b0}}) begin n_fail++; $display("FAIL reset_ce: got %b want %b", ce, {NCH{1'b0}}); end
        n_cmp++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
        n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
    endtask

    task automatic test_power_up();
        bit exp_quad;
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk25);
            exp_quad = (n >= HOLD + 5) && (((n - HOLD - 1) % 4) == 0);
            n_cmp++; if (sys_rst_n !== (n >= HOLD + 1)) begin n_fail++; $display("FAIL pwr_sys_rst_n cyc %0d: got %b want %b", n, sys_rst_n, (n >= HOLD + 1)); end
            n_cmp++; if (running !== (n >= HOLD + 1)) begin n_fail++; $display("FAIL pwr_running cyc %0d: got %b want %b", n, running, (n >= HOLD + 1)); end
            n_cmp++; if (ce[ONE_CH] !== (n >= HOLD + 2)) begin n_fail++; $display("FAIL pwr_ce_div1 cyc %0d: got %b want %b", n, ce[ONE_CH], (n >= HOLD + 2)); end
            n_cmp++; if (ce[QUAD_CH] !== exp_quad) begin n_fail++; $display("FAIL pwr_ce_div4 cyc %0d: got %b want %b", n, ce[QUAD_CH], exp_quad); end
            n_cmp++; if (ce !== m_ce) begin n_fail++; $display("FAIL pwr_ce_model cyc %0d: got %b want %b", n, ce, m_ce); end
        end
    endtask

    task automatic test_bounce();
        int quad_pulses;
        quad_pulses = 0;
        for (int j = 0; j < 52; j++) begin
            btn_n = (j >= 40) ? 1'b1 : (((j / 3) % 2) == 1);
            @(negedge clk25);
            if (j < 40 && ce[QUAD_CH]) quad_pulses++;
            n_cmp++; if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL bounce_sys_rst_n cyc %0d: got %b want 1", j, sys_rst_n); end
            n_cmp++; if (ce !== m_ce) begin n_fail++; $display("FAIL bounce_ce cyc %0d: got %b want %b", j, ce, m_ce); end
        end
        n_cmp++; if (quad_pulses != 10) begin n_fail++; $display("FAIL bounce_pulse_count: got %0d want 10", quad_pulses); end
    endtask

    task automatic test_press();
        btn_n = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk25);
            n_cmp++; if (sys_rst_n !== (j < 11)) begin n_fail++; $display("FAIL press_sys_rst_n edge+%0d: got %b want %b", j, sys_rst_n, (j < 11)); end
            if (j >= 11) begin
                n_cmp++; if (ce !== {NCH{1'b0}}) begin n_fail++; $display("FAIL press_ce_zero edge+%0d: got %b want 0", j, ce); end
            end
            n_cmp++; if (ce !== m_ce) begin n_fail++; $display("FAIL press_ce_model edge+%0d: got %b want %b", j, ce, m_ce); end
        end
        btn_n = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk25);
            n_cmp++; if (sys_rst_n !== (j >= DEB + 1 + HOLD + 1)) begin n_fail++; $display("FAIL release_sys_rst_n edge+%0d: got %b want %b", j, sys_rst_n, (j >= DEB + 1 + HOLD + 1)); end
            n_cmp++; if (ce !== m_ce) begin n_fail++; $display("FAIL release_ce_model edge+%0d: got %b want %b", j, ce, m_ce); end
        end
    endtask

    task automatic test_mid_reset();
        repeat (5) @(negedge clk25);
        n_cmp++; if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_run: got %b want 1", sys_rst_n); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (ce !== {NCH{1'b0}}) begin n_fail++; $display("FAIL midrst_async_ce: got %b want 0", ce); end
        n_cmp++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL midrst_async_sys_rst_n: got %b want 0", sys_rst_n); end
        n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL midrst_async_running: got %b want 0", running); end
        @(negedge clk25);
        rst = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk25);
            n_cmp++; if (sys_rst_n !== (n >= HOLD + 1)) begin n_fail++; $display("FAIL midrst_restretch cyc %0d: got %b want %b", n, sys_rst_n, (n >= HOLD + 1)); end
            n_cmp++; if (ce !== m_ce) begin n_fail++; $display("FAIL midrst_ce_model cyc %0d: got %b want %b", n, ce, m_ce); end
        end
    endtask

    task automatic test_full_range();
        int last;
        int npulse;
        last   = -1;
        npulse = 0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk25);
            if (ce[2]) begin
                if (last >= 0) begin
                    n_cmp++; if (n - last != 255) begin n_fail++; $display("FAIL div255_period: got %0d want 255", n - last); end
                end
                last = n;
                npulse++;
            end
            n_cmp++; if (ce[ONE_CH] !== 1'b1) begin n_fail++; $display("FAIL div1_high cyc %0d: got %b want 1", n, ce[ONE_CH]); end
        end
        n_cmp++; if (npulse < 3) begin n_fail++; $display("FAIL div255_count: got %0d want >=3", npulse); end
    endtask

    task automatic test_random();
        int seg;
        bit lvl;
        int cyc;
        cyc = 0;
        while (cyc < 2000) begin
            seg = $urandom_range(1, 14);
            lvl = ($urandom_range(0, 3) != 0);
            btn_n = lvl;
            for (int k = 0; k < seg; k++) begin
                @(negedge clk25);
                cyc++;
                n_cmp++; if (ce !== m_ce) begin n_fail++; $display("FAIL rand_ce cyc %0d: got %b want %b", cyc, ce, m_ce); end
                n_cmp++; if (sys_rst_n !== m_running) begin n_fail++; $display("FAIL rand_sys_rst_n cyc %0d: got %b want %b", cyc, sys_rst_n, m_running); end
                n_cmp++; if (running !== m_running) begin n_fail++; $display("FAIL rand_running cyc %0d: got %b want %b", cyc, running, m_running); end
            end
        end
        btn_n = 1'b1;
    endtask

`ifdef CLKGEN_STEP_EN
    task automatic test_step();
        bit seen;
        int got;
        btn_n     = 1'b1;
        step_mode = 1'b0;
        step_req  = 1'b0;
        repeat (60) @(negedge clk25);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk25);
            if (ce[0]) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL step_natural_tick: got %b want 1", seen); end
        step_mode = 1'b1;
        repeat (3) @(negedge clk25);
        got = 0;
        for (int j = 0; j < 24; j++) begin
            step_req = (j == 0) || (j == 2) || (j == 9);
            @(negedge clk25);
            if (ce[0]) got++;
            n_cmp++; if (ce[0] !== ((j == 4) || (j == 12))) begin n_fail++; $display("FAIL step_ce0 edge+%0d: got %b want %b", j, ce[0], ((j == 4) || (j == 12))); end
            n_cmp++; if (ce !== m_ce) begin n_fail++; $display("FAIL step_ce_model edge+%0d: got %b want %b", j, ce, m_ce); end
        end
        step_req = 1'b0;
        n_cmp++; if (got != 2) begin n_fail++; $display("FAIL step_pulse_count: got %0d want 2", got); end
        step_mode = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk25);
            n_cmp++; if (ce !== m_ce) begin n_fail++; $display("FAIL step_resume cyc %0d: got %b want %b", j, ce, m_ce); end
        end
    endtask
`endif

    initial begin
`ifdef CLKGEN_STEP_EN
        step_mode = 1'b0;
        step_req  = 1'b0;
`endif
        test_reset();
        test_power_up();
        test_bounce();
        test_press();
        test_mid_reset();
        test_full_range();
        test_random();
`ifdef CLKGEN_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
